// File: rtl/pll_audio_reconfig_ctrl_pkg.sv
// pll_audio_reconfig_pkg: states, reconfig register map and per-rate counter settings for the audio PLL.
package pll_audio_reconfig_pkg;
  typedef enum logic [3:0] {
    S_RST_PLL, S_MODE, S_WR_M, S_WR_K, S_WR_N, S_WR_C0, S_START,
    S_WAIT_CFG, S_WAIT_LOCK, S_IDLE, S_FAIL
  } state_t;
  localparam logic [5:0] A_MODE  = 6'h00;
  localparam logic [5:0] A_START = 6'h02;
  localparam logic [5:0] A_N     = 6'h03;
  localparam logic [5:0] A_M     = 6'h04;
  localparam logic [5:0] A_C0    = 6'h05;
  localparam logic [5:0] A_K     = 6'h07;
  localparam logic [31:0] MODE_POLL = 32'h0000_0001;
  localparam logic [31:0] START_GO  = 32'h0000_0001;
  localparam logic [31:0] M48    = 32'h0000_0606;
  localparam logic [31:0] K48    = 32'h49BA_5E35;
  localparam logic [31:0] M44    = 32'h0002_0605;
  localparam logic [31:0] K44    = 32'h4A23_39C2;
  localparam logic [31:0] N_CFG  = 32'h0001_0000;
  localparam logic [31:0] C0_CFG = 32'h0002_0D0C;
  // Non-write states map to address/data 0 so the bus idles at zero.
  function automatic logic [5:0] wr_addr(state_t s);
    case (s)
      S_MODE:  return A_MODE;
      S_WR_M:  return A_M;
      S_WR_K:  return A_K;
      S_WR_N:  return A_N;
      S_WR_C0: return A_C0;
      S_START: return A_START;
      default: return 6'h00;
    endcase
  endfunction
  function automatic logic [31:0] wr_data(state_t s, logic rate);
    case (s)
      S_MODE:  return MODE_POLL;
      S_WR_M:  return rate ? M44 : M48;
      S_WR_K:  return rate ? K44 : K48;
      S_WR_N:  return N_CFG;
      S_WR_C0: return C0_CFG;
      S_START: return START_GO;
      default: return 32'h0;
    endcase
  endfunction
endpackage

// File: rtl/pll_audio_reconfig_ctrl_if.sv
// pll_audio_reconfig_ctrl_if: Avalon-MM write-only reconfiguration port of the audio PLL.
interface pll_audio_reconfig_ctrl_if;
  logic        waitrequest;
  logic [5:0]  address;
  logic        write;
  logic [31:0] writedata;
  modport master (input waitrequest, output address, write, writedata);
  modport slave  (output waitrequest, input address, write, writedata);
endinterface

// File: rtl/pll_audio_reconfig_ctrl_lock_watch.sv
// pll_lock_watch: synchronises the asynchronous PLL lock and times out a lock wait.
module pll_lock_watch #(
  parameter int LOCK_TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_pll_locked,
  output logic o_locked_sync,
  output logic o_expired
);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(LOCK_TIMEOUT - 1);
  logic [1:0]    r_sync;
  logic [TW-1:0] r_timer;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync  <= 2'b00;
      r_timer <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_pll_locked};
      r_timer <= !i_start ? '0 : (r_timer == T_LAST) ? r_timer : r_timer + 1'b1;
    end
  assign o_locked_sync = r_sync[1];
  assign o_expired     = i_start && r_timer == T_LAST;
endmodule

// File: rtl/pll_audio_reconfig_ctrl.sv
// pll_audio_reconfig_ctrl: rewrites the audio PLL counters for the 48 kHz / 44.1 kHz clock family
// through its reconfig port, then supervises lock with timeout and bounded retry.
module pll_audio_reconfig_ctrl
  import pll_audio_reconfig_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 1_000_000,
  parameter int MAX_RETRY    = 3,
  parameter int RST_CYCLES   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rate_sel,
  input  logic i_pll_locked,
  pll_audio_reconfig_ctrl_if.master mgmt,
  output logic o_pll_rst,
  output logic o_busy,
  output logic o_ready,
  output logic o_error,
  output logic o_cur_rate
);
  localparam int CW = $clog2(RST_CYCLES);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_retry;
  logic          r_target, r_pend, r_rate_q, r_fresh, r_cur_rate;
  logic          w_locked, w_expired, w_wait_lock;
  assign w_wait_lock = r_state == S_WAIT_LOCK;
  pll_lock_watch #(.LOCK_TIMEOUT(LOCK_TIMEOUT)) u_lock_watch (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (w_wait_lock),
    .i_pll_locked (i_pll_locked),
    .o_locked_sync(w_locked),
    .o_expired    (w_expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= S_RST_PLL;
      r_cnt      <= '0;
      r_retry    <= '0;
      r_target   <= 1'b0;
      r_pend     <= 1'b0;
      r_rate_q   <= 1'b0;
      r_fresh    <= 1'b1;
      r_cur_rate <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= (r_state == S_RST_PLL && r_cnt != CNT_LAST) ? r_cnt + 1'b1 : '0;
      r_fresh  <= 1'b0;
      r_rate_q <= i_rate_sel;
      // Target is captured on the first cycle after reset and on every start from IDLE.
      if (r_fresh || (r_state == S_IDLE && w_next == S_MODE)) r_target <= i_rate_sel;
      r_pend <= (r_state == S_IDLE) ? 1'b0 : r_pend | (o_busy && !r_fresh && i_rate_sel != r_rate_q);
      if (w_wait_lock && w_locked) begin
        r_cur_rate <= r_target;
        r_retry    <= '0;
      end else if (w_expired && r_retry < RETRY_MAX) r_retry <= r_retry + 1'b1;
    end
  // Write states and WAIT_CFG are contiguous in the enum and all advance on a free port.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST_PLL: w_next = (r_cnt == CNT_LAST) ? S_MODE : S_RST_PLL;
      S_MODE, S_WR_M, S_WR_K, S_WR_N, S_WR_C0, S_START, S_WAIT_CFG:
        w_next = mgmt.waitrequest ? r_state : state_t'(r_state + 4'd1);
      S_WAIT_LOCK: w_next = w_locked ? S_IDLE : !w_expired ? S_WAIT_LOCK :
                            (r_retry < RETRY_MAX) ? S_RST_PLL : S_FAIL;
      S_IDLE: w_next = !w_locked ? S_RST_PLL :
                       (r_pend || i_rate_sel != r_cur_rate) ? S_MODE : S_IDLE;
      default: w_next = r_state;
    endcase
  end
  always_comb begin
    mgmt.write     = r_state inside {[S_MODE:S_START]};
    mgmt.address   = wr_addr(r_state);
    mgmt.writedata = wr_data(r_state, r_target);
    o_pll_rst      = r_state == S_RST_PLL;
    o_busy         = r_state != S_IDLE && r_state != S_FAIL;
    o_ready        = r_state == S_IDLE && w_locked;
    o_error        = r_state == S_FAIL;
  end
  assign o_cur_rate = r_cur_rate;
endmodule

// File: tb/tb_pll_audio_reconfig_ctrl.sv
// tb_pll_audio_reconfig_ctrl: scoreboarded write sequences, table-driven rate switches, and
// hand sequences for stall, rate toggling, mid-write reset and lock timeout.
module tb_pll_audio_reconfig_ctrl;
  typedef struct packed {logic [5:0] a; logic [31:0] d;} wr_t;
  typedef struct {logic rate; logic [31:0] m; logic [31:0] k;} vec_t;
  localparam logic [31:0] EM48 = 32'h0000_0606, EK48 = 32'h49BA_5E35;
  localparam logic [31:0] EM44 = 32'h0002_0605, EK44 = 32'h4A23_39C2;
  logic clk = 1'b0, rst_n = 1'b0, rate_sel = 1'b0, model_lock = 1'b0, lock_en = 1'b1;
  logic pll_locked, pll_rst, busy, ready, error, cur_rate, prev_rst = 1'b0;
  wr_t  exp_q[$];
  wr_t  got, want;
  vec_t vecs[4];
  int   n_chk = 0, n_pass = 0, mon_chk = 0, mon_pass = 0, pulses = 0, lk_cnt = 0, n_acc = 0;
  int   base, acc0, h, n;
  assign pll_locked = model_lock & lock_en;
  pll_audio_reconfig_ctrl_if mgmt();
  pll_audio_reconfig_ctrl #(.LOCK_TIMEOUT(100), .MAX_RETRY(3), .RST_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_rate_sel(rate_sel), .i_pll_locked(pll_locked), .mgmt(mgmt),
    .o_pll_rst(pll_rst), .o_busy(busy), .o_ready(ready), .o_error(error), .o_cur_rate(cur_rate)
  );
  always #5 clk = ~clk;
  // Bus monitor, pll_rst pulse counter and PLL lock model (lock returns 50 cycles after START).
  initial forever begin
    @(negedge clk);
    if (pll_rst && !prev_rst) pulses++;
    prev_rst = pll_rst;
    if (rst_n && mgmt.write && !mgmt.waitrequest) begin
      n_acc++;
      mon_chk++;
      got = {mgmt.address, mgmt.writedata};
      if (exp_q.size() == 0) $display("FAIL unexpected write: got %0h:%0h, none required", got.a, got.d);
      else begin
        want = exp_q.pop_front();
        if (got == want) mon_pass++;
        else $display("FAIL write order: got %0h:%0h required %0h:%0h", got.a, got.d, want.a, want.d);
      end
    end
    if (rst_n && mgmt.write && !mgmt.waitrequest && mgmt.address == 6'h02) begin
      model_lock = 1'b0;
      lk_cnt = 50;
    end else if (lk_cnt > 0) begin
      lk_cnt--;
      if (lk_cnt == 0) model_lock = 1'b1;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask
  task automatic push_seq(input logic [31:0] m, input logic [31:0] k);
    exp_q.push_back({6'h00, 32'h0000_0001});
    exp_q.push_back({6'h04, m});
    exp_q.push_back({6'h07, k});
    exp_q.push_back({6'h03, 32'h0001_0000});
    exp_q.push_back({6'h05, 32'h0002_0D0C});
    exp_q.push_back({6'h02, 32'h0000_0001});
  endtask
  task automatic wait_ready(input string nm, input int budget);
    int c = 0;
    do begin @(negedge clk); c++; end while (!ready && c < budget);
    chk(nm, ready, 1);
  endtask
  task automatic wait_addr(input logic [5:0] a, input string nm);
    int c = 0;
    do begin @(negedge clk); c++; end while (!(mgmt.write && mgmt.address == a) && c < 400);
    chk(nm, mgmt.write && mgmt.address == a, 1);
  endtask
  initial begin
    vecs[0] = '{1'b1, EM44, EK44};
    vecs[1] = '{1'b0, EM48, EK48};
    vecs[2] = '{1'b1, EM44, EK44};
    vecs[3] = '{1'b0, EM48, EK48};
    mgmt.waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outputs", {mgmt.address, mgmt.write, pll_rst, busy, ready, error, cur_rate}, 12'b000000_0_1_1_0_0_0);
    chk("reset writedata", mgmt.writedata, 0);
    push_seq(EM48, EK48);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_ready("initial ready", 500);
    chk("initial cur_rate", cur_rate, 0);
    chk("initial writes done", exp_q.size(), 0);
    chk("initial pll_rst low", pll_rst, 0);
    for (int i = 0; i < 4; i++) begin
      base = pulses;
      push_seq(vecs[i].m, vecs[i].k);
      @(posedge clk); #1 rate_sel = vecs[i].rate;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("switch busy", busy, 1);
      wait_ready("switch ready", 500);
      chk("switch cur_rate", cur_rate, vecs[i].rate);
      chk("switch no pll_rst pulse", pulses - base, 0);
      chk("switch writes done", exp_q.size(), 0);
    end
    push_seq(EM44, EK44);
    @(posedge clk); #1 rate_sel = 1'b1;
    wait_addr(6'h04, "stall reach WR_M");
    @(posedge clk); #1 mgmt.waitrequest = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("stall K held", {mgmt.write, mgmt.address, mgmt.writedata}, {1'b1, 6'h07, EK44});
    end
    @(posedge clk); #1 mgmt.waitrequest = 1'b0;
    wait_ready("stall ready", 500);
    chk("stall writes done", exp_q.size(), 0);
    @(posedge clk); #1 rst_n = 1'b0;
    rate_sel = 1'b0;
    exp_q.delete();
    push_seq(EM48, EK48);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_addr(6'h02, "toggle first START");
    repeat (3) @(posedge clk);
    #1 rate_sel = 1'b1;
    @(posedge clk); #1 rate_sel = 1'b0;
    @(posedge clk); #1 rate_sel = 1'b1;
    push_seq(EM44, EK44);
    @(negedge clk);
    chk("toggle waiting lock", {busy, ready}, 2'b10);
    wait_addr(6'h02, "toggle second START");
    wait_ready("toggle ready", 500);
    chk("toggle cur_rate", cur_rate, 1);
    acc0 = n_acc;
    repeat (200) @(negedge clk);
    chk("toggle no third sequence", n_acc - acc0, 0);
    chk("toggle stays ready", {busy, ready}, 2'b01);
    @(posedge clk); #1 rate_sel = 1'b0;
    push_seq(EM48, EK48);
    wait_addr(6'h03, "reach WR_N");
    #1 rst_n = 1'b0;
    #1 chk("mid-WR_N reset outputs", {mgmt.address, mgmt.write, pll_rst, busy, ready, error, cur_rate}, 12'b000000_0_1_1_0_0_0);
    chk("mid-WR_N reset writedata", mgmt.writedata, 0);
    exp_q.delete();
    push_seq(EM48, EK48);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    h = 0;
    do begin @(negedge clk); if (pll_rst) h++; end while (pll_rst && h < 100);
    chk("fresh pll_rst width", h, 16);
    wait_ready("fresh ready", 500);
    chk("fresh cur_rate", cur_rate, 0);
    base = pulses;
    @(posedge clk); #1 rst_n = 1'b0;
    lock_en = 1'b0;
    rate_sel = 1'b1;
    exp_q.delete();
    repeat (4) push_seq(EM44, EK44);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!error && n < 3000);
    chk("timeout error", error, 1);
    chk("timeout busy/ready/pll_rst", {busy, ready, pll_rst}, 3'b000);
    chk("timeout pll_rst pulses", pulses - base, 4);
    chk("timeout writes done", exp_q.size(), 0);
    repeat (20) @(negedge clk);
    chk("error sticky", {error, busy}, 2'b10);
    $display("%0d/%0d checks passed", n_pass + mon_pass, n_chk + mon_chk);
    $finish;
  end
endmodule
